// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
// Converts single outstanding CPU memory requests (valid/ready style) into
// AXI4-Lite read or write transactions and returns the result as a
// one-cycle mem_ready pulse carrying read data and an error flag.
//
// Optional feature: define MEM_AXI_TIMEOUT_EN to add a per-transaction
// wait-cycle limit (TIMEOUT_CYCLES). When the limit is hit the bridge gives
// up, drops its AXI valids and completes with mem_rdata=32'hFFFFFFFF and
// bus_err=1. Without the macro there is no counter and the bridge waits
// forever for the slave.
module mem_axi_bridge #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        mem_valid,
   input  logic        mem_instr,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,

   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp,

   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [2:0]  arprot,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,

   output logic        bus_err
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_RESP,
      WR_REQ,
      WR_RESP,
      ACK
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        instr_q;
   logic        aw_pend;
   logic        w_pend;

   logic        busy;
   logic        timeout;
   logic        rsp_load;
   logic        rsp_err;
   logic        rdata_load;
   logic [31:0] rdata_val;

   // A zero limit would make every transaction fail immediately
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_axi_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   assign busy = (state == RD_ADDR) || (state == RD_RESP) ||
                 (state == WR_REQ)  || (state == WR_RESP);

`ifdef MEM_AXI_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;

   // Count every cycle spent waiting on the slave; cleared whenever idle or acking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (busy) begin
         wait_cnt <= wait_cnt + CW'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   assign timeout = busy && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register; reset abandons whatever transaction was in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the decision of what (if anything) to capture as the response
   always_comb begin
      state_next = state;
      rsp_load   = 1'b0;
      rsp_err    = 1'b0;
      rdata_load = 1'b0;
      rdata_val  = rdata;

      case (state)
         IDLE: begin
            if (mem_valid) begin
               state_next = (mem_wstrb == 4'b0000) ? RD_ADDR : WR_REQ;
            end
         end
         RD_ADDR: begin
            if (arready) begin
               state_next = RD_RESP;
            end
         end
         RD_RESP: begin
            if (rvalid) begin
               state_next = ACK;
               rsp_load   = 1'b1;
               rsp_err    = (rresp != 2'b00);
               rdata_load = 1'b1;
            end
         end
         WR_REQ: begin
            if ((!aw_pend || awready) && (!w_pend || wready)) begin
               state_next = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               state_next = ACK;
               rsp_load   = 1'b1;
               rsp_err    = (bresp != 2'b00);
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (timeout && (state_next != ACK)) begin
         state_next = ACK;
         rsp_load   = 1'b1;
         rsp_err    = 1'b1;
         rdata_load = 1'b1;
         rdata_val  = 32'hFFFF_FFFF;
      end
   end

   // Capture the CPU request on acceptance and track which write channels are still outstanding
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         instr_q <= 1'b0;
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
      end else if ((state == IDLE) && mem_valid) begin
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         wstrb_q <= mem_wstrb;
         instr_q <= mem_instr;
         aw_pend <= (mem_wstrb != 4'b0000);
         w_pend  <= (mem_wstrb != 4'b0000);
      end else if (state == WR_REQ) begin
         if (awready) begin
            aw_pend <= 1'b0;
         end
         if (wready) begin
            w_pend <= 1'b0;
         end
      end
   end

   // Response registers; mem_rdata only changes on reads or timeouts
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rdata <= '0;
         bus_err   <= 1'b0;
      end else if (rsp_load) begin
         bus_err <= rsp_err;
         if (rdata_load) begin
            mem_rdata <= rdata_val;
         end
      end
   end

   assign mem_ready = (state == ACK);

   assign arvalid   = (state == RD_ADDR);
   assign araddr    = addr_q;
   assign arprot    = {instr_q, 2'b00};
   assign rready    = 1'b1;

   assign awvalid   = (state == WR_REQ) && aw_pend;
   assign awaddr    = addr_q;
   assign wvalid    = (state == WR_REQ) && w_pend;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign bready    = 1'b1;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge
// Scoreboard bench: each issued CPU request pushes its expected completion
// into a queue; a monitor pops and compares on every mem_ready. A simple
// AXI slave with per-transaction random delays checks the AXI side.
// With MEM_AXI_TIMEOUT_EN defined an extra timeout scenario is exercised.
module tb_mem_axi_bridge;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        bus_err;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      bit          instr;
      logic [31:0] rd;
      logic [1:0]  resp;
      int          aw_dly;
      int          w_dly;
      int          ar_dly;
      int          r_dly;
      bit          drop_valid;
      bit          no_resp;
      bit          timeout;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   txn_t        slv_q[$];
   exp_t        exp_q[$];
   logic [31:0] last_rdata;
   int          n_cmp;
   int          n_fail;

   mem_axi_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .bus_err(bus_err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic noteFail(input string name, input string what);
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_arvalid"},   32'(arvalid),   32'd0);
      checkOutput({tag, "_awvalid"},   32'(awvalid),   32'd0);
      checkOutput({tag, "_wvalid"},    32'(wvalid),    32'd0);
      checkOutput({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
      checkOutput({tag, "_bus_err"},   32'(bus_err),   32'd0);
      checkOutput({tag, "_mem_rdata"}, mem_rdata,      32'd0);
   endtask

   function automatic txn_t mkTxn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] ws, input bit instr, input logic [31:0] rd,
                                  input logic [1:0] resp, input int aw_d, input int w_d,
                                  input int ar_d, input int r_d);
      txn_t t;
      t.wr = wr; t.addr = addr; t.wdata = wd; t.wstrb = ws; t.instr = instr;
      t.rd = rd; t.resp = resp; t.aw_dly = aw_d; t.w_dly = w_d; t.ar_dly = ar_d;
      t.r_dly = r_d; t.drop_valid = 1'b0; t.no_resp = 1'b0; t.timeout = 1'b0;
      return t;
   endfunction

   function automatic txn_t randTxn();
      txn_t t;
      t.wr         = 1'($urandom_range(0, 1));
      t.addr       = $urandom;
      t.wdata      = $urandom;
      t.wstrb      = 4'($urandom_range(1, 15));
      t.instr      = !t.wr && ($urandom_range(0, 3) == 0);
      t.rd         = $urandom;
      t.resp       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t.aw_dly     = int'($urandom_range(0, 2));
      t.w_dly      = int'($urandom_range(0, 2));
      t.ar_dly     = int'($urandom_range(0, 2));
      t.r_dly      = int'($urandom_range(0, 2));
      t.drop_valid = ($urandom_range(0, 4) == 0);
      t.no_resp    = 1'b0;
      t.timeout    = 1'b0;
      return t;
   endfunction

   // Reference model: expected completion from the request and the slave's planned reply
   task automatic applyStimulus(input txn_t t, output int lat, output int ar_cnt);
      exp_t e;
      int   n;
      lat    = 0;
      ar_cnt = 0;
      if (!t.no_resp || t.timeout) begin
         if (t.timeout) begin
            e.rdata = 32'hFFFF_FFFF;
            e.err   = 1'b1;
         end else begin
            e.rdata = t.wr ? last_rdata : t.rd;
            e.err   = (t.resp != 2'b00);
         end
         last_rdata = e.rdata;
         exp_q.push_back(e);
      end
      slv_q.push_back(t);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = t.addr;
      mem_wdata = t.wr ? t.wdata : $urandom;
      mem_wstrb = t.wr ? t.wstrb : 4'b0000;
      mem_instr = t.instr;
      if (t.no_resp && !t.timeout) return;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (arvalid === 1'b1) ar_cnt++;
         if (mem_ready === 1'b1) break;
         if (t.drop_valid && n == 0) begin
            mem_valid = 1'b0;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_wstrb = 4'($urandom);
            mem_instr = ~mem_instr;
         end
         n++;
      end
      if (n >= 100) noteFail("mem_ready_wait", "no mem_ready within 100 cycles");
      lat       = n + 2;
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      mem_instr = 1'b0;
   endtask

   task automatic slaveRead(input txn_t t);
      int n;
      n = 0;
      while (arvalid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         noteFail("arvalid_start", "arvalid never rose");
         return;
      end
      if (t.no_resp) return;
      repeat (t.ar_dly) begin
         @(negedge clk);
         checkOutput("arvalid_hold", 32'(arvalid), 32'd1);
      end
      checkOutput("araddr", araddr, t.addr);
      checkOutput("arprot", 32'(arprot), 32'({t.instr, 2'b00}));
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      checkOutput("arvalid_drop", 32'(arvalid), 32'd0);
      repeat (t.r_dly) @(negedge clk);
      rvalid = 1'b1;
      rdata  = t.rd;
      rresp  = t.resp;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'($urandom);
   endtask

   task automatic slaveWrite(input txn_t t);
      int n;
      int c;
      bit aw_done;
      bit w_done;
      n = 0;
      while (!(awvalid === 1'b1 || wvalid === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         noteFail("aw_w_start", "awvalid/wvalid never rose");
         return;
      end
      checkOutput("awvalid_start", 32'(awvalid), 32'd1);
      checkOutput("wvalid_start",  32'(wvalid),  32'd1);
      c = 0; aw_done = 1'b0; w_done = 1'b0;
      while (!(aw_done && w_done) && c < 50) begin
         awready = !aw_done && (c >= t.aw_dly);
         wready  = !w_done  && (c >= t.w_dly);
         if (awready) checkOutput("awaddr", awaddr, t.addr);
         if (wready) begin
            checkOutput("wdata", wdata, t.wdata);
            checkOutput("wstrb", 32'(wstrb), 32'(t.wstrb));
         end
         @(negedge clk);
         if (awready) aw_done = 1'b1;
         if (wready)  w_done  = 1'b1;
         c++;
         checkOutput("awvalid_track", 32'(awvalid), 32'(!aw_done));
         checkOutput("wvalid_track",  32'(wvalid),  32'(!w_done));
      end
      awready = 1'b0;
      wready  = 1'b0;
      if (c >= 50) noteFail("aw_w_handshake", "handshakes did not complete");
      if (t.no_resp) return;
      repeat (t.r_dly) @(negedge clk);
      bvalid = 1'b1;
      bresp  = t.resp;
      @(negedge clk);
      bvalid = 1'b0;
      bresp  = 2'($urandom);
   endtask

   // AXI slave: serves one planned transaction at a time
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (slv_q.size() > 0) begin
            t = slv_q.pop_front();
            if (t.wr) slaveWrite(t);
            else      slaveRead(t);
         end
      end
   end

   // Monitor: every mem_ready must match the oldest expected completion
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               noteFail("unexpected_ready", "got mem_ready=1, required 0");
            end else begin
               e = exp_q.pop_front();
               checkOutput("mem_rdata", mem_rdata, e.rdata);
               checkOutput("bus_err", 32'(bus_err), 32'(e.err));
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main stimulus sequence
   initial begin
      txn_t t;
      int   lat;
      int   ar_cnt;
      n_cmp = 0; n_fail = 0; last_rdata = 32'd0;
      reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
      mem_wdata = '0; mem_wstrb = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

      repeat (3) @(negedge clk);
      checkResetState("por");
      checkOutput("bready_const", 32'(bready), 32'd1);
      checkOutput("rready_const", 32'(rready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      t = mkTxn(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0);
      applyStimulus(t, lat, ar_cnt);
      checkOutput("read_latency", 32'(lat), 32'd4);

      t = mkTxn(1'b1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0, 32'h0, 2'b00, 3, 0, 0, 1);
      applyStimulus(t, lat, ar_cnt);

      t = mkTxn(1'b1, 32'h300, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0);
      applyStimulus(t, lat, ar_cnt);
      checkOutput("write_latency", 32'(lat), 32'd4);

      t = mkTxn(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0BAD_0BAD, 2'b10, 0, 0, 1, 0);
      applyStimulus(t, lat, ar_cnt);

      t = mkTxn(1'b1, 32'h500, 32'h5555_AAAA, 4'b1000, 1'b0, 32'h0, 2'b11, 0, 2, 0, 0);
      t.drop_valid = 1'b1;
      applyStimulus(t, lat, ar_cnt);

      // Reset while a read address is being presented
      t = mkTxn(1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0);
      t.no_resp = 1'b1;
      applyStimulus(t, lat, ar_cnt);
      repeat (2) @(negedge clk);
      checkOutput("pre_reset_arvalid", 32'(arvalid), 32'd1);
      #2 reset = 1'b1;
      #1 checkResetState("rst_rdaddr");
      mem_valid = 1'b0; mem_wstrb = 4'b0000; last_rdata = 32'd0;
      @(negedge clk);
      reset = 1'b0;

      // Reset while waiting for the write response, then a stray bvalid
      t = mkTxn(1'b1, 32'h700, 32'h7777_7777, 4'b0101, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0);
      t.no_resp = 1'b1;
      applyStimulus(t, lat, ar_cnt);
      repeat (3) @(negedge clk);
      checkOutput("wr_resp_wait_ready", 32'(mem_ready), 32'd0);
      #2 reset = 1'b1;
      #1 checkResetState("rst_wrresp");
      mem_valid = 1'b0; mem_wstrb = 4'b0000; last_rdata = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bvalid = 1'b1;
      bresp  = 2'b00;
      @(negedge clk);
      bvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("stray_bvalid_ready", 32'(mem_ready), 32'd0);
      end

`ifdef MEM_AXI_TIMEOUT_EN
      t = mkTxn(1'b0, 32'h800, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00, 0, 0, 0, 0);
      t.no_resp = 1'b1;
      t.timeout = 1'b1;
      applyStimulus(t, lat, ar_cnt);
      checkOutput("timeout_arvalid_cycles", 32'(ar_cnt), 32'd8);
      @(negedge clk);
      checkOutput("timeout_arvalid_after", 32'(arvalid), 32'd0);
`endif

      for (int k = 0; k < 150; k++) begin
         t = randTxn();
         applyStimulus(t, lat, ar_cnt);
      end

      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) noteFail("drain", "expected completions never arrived");
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_axi_bridge.md
MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the wait-cycle limit per AXI transaction (used only with MEM_AXI_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports are listed in REQ-003 to REQ-030.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mem_valid  in  1  CPU request; held high until mem_ready.
REQ-006 mem_instr  in  1  request is instruction fetch.
REQ-007 mem_ready  out  1  one-cycle completion pulse.
REQ-008 mem_addr  in  32  byte address.
REQ-009 mem_wdata  in  32  store data.
REQ-010 mem_wstrb  in  4  byte enables; 0 = read.
REQ-011 mem_rdata  out  32  read data, valid with mem_ready.
REQ-012 awvalid  out  1  AXI write-address valid.
REQ-013 awready  in  1  AXI write-address ready.
REQ-014 awaddr  out  32  AXI write address.
REQ-015 wvalid  out  1  AXI write-data valid.
REQ-016 wready  in  1  AXI write-data ready.
REQ-017 wdata  out  32  AXI write data.
REQ-018 wstrb  out  4  AXI write strobes.
REQ-019 bvalid  in  1  AXI write-response valid.
REQ-020 bready  out  1  AXI write-response ready.
REQ-021 bresp  in  2  AXI write response.
REQ-022 arvalid  out  1  AXI read-address valid.
REQ-023 arready  in  1  AXI read-address ready.
REQ-024 araddr  out  32  AXI read address.
REQ-025 arprot  out  3  {mem_instr latched, 0, 0}.
REQ-026 rvalid  in  1  AXI read-data valid.
REQ-027 rready  out  1  AXI read-data ready.
REQ-028 rdata  in  32  AXI read data.
REQ-029 rresp  in  2  AXI read response.
REQ-030 bus_err  out  1  error flag, valid only with mem_ready.

Function
REQ-031 SHALL implement states IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP, ACK.
REQ-032 SHALL, in IDLE with mem_valid=1, latch addr/wdata/wstrb/instr and go to RD_ADDR (wstrb=0, arvalid=1) or WR_REQ (awvalid=wvalid=1) on the next edge.
REQ-033 SHALL drop arvalid on arready handshake, then enter RD_RESP.
REQ-034 SHALL drop awvalid and wvalid independently on their own handshakes, in either order or the same cycle, and enter WR_RESP once both have completed.
REQ-035 SHALL drive bready=1 and rready=1 constantly; in IDLE, responses are absorbed and ignored.
REQ-036 SHALL, on rvalid in RD_RESP, register rdata into mem_rdata and set bus_err=(rresp!=0), then go to ACK; on bvalid in WR_RESP, set bus_err=(bresp!=0), leave mem_rdata unchanged, then go to ACK.
REQ-037 SHALL hold mem_ready=1 for exactly the ACK cycle and return to IDLE unconditionally, ignoring mem_valid during ACK.
REQ-038 SHALL keep every AXI address/data/strobe output stable while its valid is high; minimum latency from mem_valid to mem_ready is 4 cycles with zero-wait slave.
REQ-039 SHALL ignore mem_valid deassertion mid-transaction and still complete the transaction and pulse mem_ready.

Reset
REQ-040 SHALL, on reset asserted at any time including mid-transaction, immediately force IDLE; awvalid, wvalid, arvalid, mem_ready, bus_err all 0; mem_rdata=0; counter=0; the in-flight transaction is abandoned.

Configuration
REQ-041 SHALL, with MEM_AXI_TIMEOUT_EN defined, count cycles spent in RD_ADDR/RD_RESP/WR_REQ/WR_RESP; on reaching TIMEOUT_CYCLES, drop all AXI valids, set mem_rdata=32'hFFFFFFFF, bus_err=1, and go to ACK; counter clears in IDLE. Without the macro, no counter exists and the bridge waits indefinitely.

Verification
REQ-042 Read 0x100, arready=1, rvalid next cycle with rdata=0xDEADBEEF, rresp=0 -> araddr=0x100, mem_rdata=0xDEADBEEF, one-cycle mem_ready, bus_err=0.
REQ-043 Write 0x200, wdata=0x12345678, wstrb=4'b0011, wready 3 cycles before awready -> wvalid drops first, awvalid later, one mem_ready after bvalid.
REQ-044 Fetch with mem_instr=1, rresp=2'b10 -> arprot=3'b100, bus_err=1 with mem_ready.
REQ-045 Reset asserted while in WR_RESP -> all valids and mem_ready 0 in the same cycle; a later stray bvalid is absorbed with no mem_ready.
REQ-046 With MEM_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=8, arready held 0 -> arvalid drops after 8 cycles, mem_rdata=0xFFFFFFFF, bus_err=1, mem_ready pulses.
